// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the three-requester memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE = 16;
    localparam int NUM_REQ   = 3;

    typedef logic [WORD_SIZE-1:0] word_t;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;

    localparam logic [1:0] REQ_IF  = 2'd0;
    localparam logic [1:0] REQ_LS  = 2'd1;
    localparam logic [1:0] REQ_DMA = 2'd2;

    // Context latched at grant time and held until the next grant.
    typedef struct packed {
        logic [1:0] id;
        logic       we;
    } grant_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

    function automatic logic [1:0] wrap3(input logic [1:0] id);
        return (id == REQ_DMA) ? REQ_IF : id + 2'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter, master = environment.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] we;
    word_t              addr0, addr1, addr2;
    word_t              wdata0, wdata1, wdata2;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic               err;
    word_t              rdata;
    logic [1:0]         sel;
    logic               mem_req;
    logic               mem_we;
    word_t              mem_addr;
    word_t              mem_wdata;
    logic               mem_ready;
    word_t              mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_ready, mem_rdata,
        output gnt, done, err, rdata, sel, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_ready, mem_rdata,
        input  gnt, done, err, rdata, sel, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// Plain 3:1 word mux steering the granted requester's address/data onto the memory port.
module mux_3to1 #(
    parameter int W = 16
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);
    always_comb begin
        case (sel)
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in0;
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant picker. Build option ROUND_ROBIN_EN: rotate from rr_ptr+1;
// otherwise fixed priority 0 > 1 > 2 and rr_ptr is ignored.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [1:0]         rr_ptr,
    output logic               valid,
    output logic [1:0]         id
);
    assign valid = |eligible;

`ifdef ROUND_ROBIN_EN
    logic [1:0] s0, s1, s2;

    // Lowest-priority candidate first so the nearest one after rr_ptr overwrites it.
    always_comb begin
        s0 = wrap3(rr_ptr);
        s1 = wrap3(s0);
        s2 = wrap3(s1);
        id = REQ_IF;
        if (eligible[s2]) id = s2;
        if (eligible[s1]) id = s1;
        if (eligible[s0]) id = s0;
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    always_comb begin
        id = REQ_DMA;
        if (eligible[1]) id = REQ_LS;
        if (eligible[0]) id = REQ_IF;
    end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, load/store and DMA: grant, issue, wait for ready or watchdog.
// Build option ROUND_ROBIN_EN (in arb_pick) selects round-robin instead of fixed priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    logic [1:0]           state;
    logic [TIMEOUT_W-1:0] wdog;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic [1:0]           rr_ptr;
    grant_t               cur;
    logic [NUM_REQ-1:0]   gnt_q, done_q, eligible;
    logic                 err_q, mem_req_q;
    word_t                rdata_q, mem_addr_w, mem_wdata_w;
    logic                 pick_valid, in_txn, finish, timeout;
    logic [1:0]           pick_id;

    // A requester still sees its own done this cycle and cannot be re-granted yet.
    assign eligible = bus.req & ~done_q;
    assign in_txn   = (state == ARB_ISSUE) || (state == ARB_WAIT);
    assign finish   = in_txn && bus.mem_ready;
    assign wdog_inc = wdog + 1'b1;
    assign timeout  = (state == ARB_WAIT) && (wdog_inc == TIMEOUT_W'(TIMEOUT));

    arb_pick u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .valid    (pick_valid),
        .id       (pick_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cur       <= '0;
            mem_req_q <= 1'b0;
            wdog      <= '0;
            rr_ptr    <= REQ_DMA;
        end else begin
            done_q    <= '0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q     <= id_onehot(pick_id);
                        cur.id    <= pick_id;
                        cur.we    <= bus.we[pick_id];
                        rr_ptr    <= pick_id;
                        mem_req_q <= 1'b1;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    wdog  <= '0;
                    state <= ARB_WAIT;
                end
                ARB_WAIT: wdog <= wdog_inc;
                default:  state <= ARB_IDLE;
            endcase
            // Completion overrides the transition above; a ready on the timeout cycle wins.
            if (finish || timeout) begin
                done_q <= gnt_q;
                gnt_q  <= '0;
                err_q  <= ~bus.mem_ready;
                state  <= ARB_IDLE;
                if (bus.mem_ready && !cur.we)
                    rdata_q <= bus.mem_rdata;
            end
        end
    end

    mux_3to1 #(.W(WORD_SIZE)) u_addr_mux (
        .in0 (bus.addr0),
        .in1 (bus.addr1),
        .in2 (bus.addr2),
        .sel (cur.id),
        .out (mem_addr_w)
    );

    mux_3to1 #(.W(WORD_SIZE)) u_wdata_mux (
        .in0 (bus.wdata0),
        .in1 (bus.wdata1),
        .in2 (bus.wdata2),
        .sel (cur.id),
        .out (mem_wdata_w)
    );

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.sel       = cur.id;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cur.we;
    assign bus.mem_addr  = mem_addr_w;
    assign bus.mem_wdata = mem_wdata_w;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random requesters and memory against a cycle-counting transaction model of the arbiter.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TMO = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [2:0] rq, wq;
    word_t      a [3];
    word_t      d [3];
    logic       mr;
    word_t      md;

    // Expected registered outputs for the coming cycle plus the open transaction.
    logic [2:0] e_gnt, e_done;
    logic       e_err, e_mem_req, e_we;
    word_t      e_rdata;
    int         e_sel, e_rr;
    bit         act;
    int         issue_cyc, rdy_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        e_gnt = '0; e_done = '0; e_err = 1'b0; e_mem_req = 1'b0; e_we = 1'b0;
        e_rdata = '0; e_sel = 0; e_rr = 2; act = 1'b0; rdy_cyc = -1;
        rq = '0; wq = '0; mr = 1'b0; md = '0;
        for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
    endtask

    task automatic drive();
        bus.req = rq; bus.we = wq;
        bus.addr0 = a[0]; bus.addr1 = a[1]; bus.addr2 = a[2];
        bus.wdata0 = d[0]; bus.wdata1 = d[1]; bus.wdata2 = d[2];
        bus.mem_ready = mr; bus.mem_rdata = md;
    endtask

    function automatic int pick(input logic [2:0] el, input int rr);
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++)
            if (el[(rr + k) % 3]) return (rr + k) % 3;
`else
        for (int k = 0; k < 3; k++)
            if (el[k]) return k;
`endif
        return -1;
    endfunction

    // Cycles after mem_req at which memory answers; weighted toward the watchdog edge.
    function automatic int choose_lat();
        int r;
        r = int'($urandom_range(9, 0));
        if (r <= 3) return r;
        if (r == 4) return TMO - 1;
        if (r <= 6) return TMO;
        if (r == 7) return TMO + 1;
        if (r == 8) return 1000;
        return int'($urandom_range(TMO, 0));
    endfunction

    task automatic step();
        logic [2:0] done_now;
        int id, k;
        @(posedge clk);
        cyc++;
        #2;
        chk("gnt", bus.gnt, e_gnt);
        chk("done", bus.done, e_done);
        chk("err", bus.err, e_err);
        chk("rdata", bus.rdata, e_rdata);
        chk("mem_req", bus.mem_req, e_mem_req);
        chk("sel", bus.sel, e_sel);
        chk("mem_we", bus.mem_we, e_we);

        for (int i = 0; i < 3; i++) begin
            if (e_done[i]) rq[i] = 1'b0;
            if (!rq[i] && $urandom_range(3, 0) == 0) begin
                rq[i] = 1'b1;
                wq[i] = 1'($urandom_range(1, 0));
                a[i]  = word_t'($urandom);
                d[i]  = word_t'($urandom);
            end
        end
        mr = (cyc == rdy_cyc) || (!act && $urandom_range(7, 0) == 0);
        md = word_t'($urandom);
        drive();
        #1;
        chk("mem_addr", bus.mem_addr, a[e_sel]);
        chk("mem_wdata", bus.mem_wdata, d[e_sel]);

        done_now = e_done;
        e_done = '0; e_err = 1'b0; e_mem_req = 1'b0;
        if (!act) begin
            id = pick(rq & ~done_now, e_rr);
            if (id >= 0) begin
                act = 1'b1;
                issue_cyc = cyc + 1;
                rdy_cyc = issue_cyc + choose_lat();
                e_gnt = 3'b001 << id;
                e_sel = id;
                e_we = wq[id];
                e_mem_req = 1'b1;
                e_rr = id;
            end
        end else begin
            k = cyc - issue_cyc;
            if (mr || k == TMO) begin
                e_done = e_gnt;
                e_gnt = '0;
                e_err = !mr;
                act = 1'b0;
                if (mr && !e_we) e_rdata = md;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        bit found;
        model_reset();
        drive();
        #12;
        chk("rst_gnt", bus.gnt, 3'b000);
        chk("rst_done", bus.done, 3'b000);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_sel", bus.sel, 2'd0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        repeat (3000) step();

        found = 1'b0;
        for (int t = 0; t < 300 && !found; t++) begin
            step();
            if (act && issue_cyc <= cyc) found = 1'b1;
        end
        chk("reach_wait", found, 1'b1);
        @(posedge clk);
        #2;
        chk("wait_gnt", bus.gnt, e_gnt);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", bus.gnt, 3'b000);
        chk("mid_rst_done", bus.done, 3'b000);
        chk("mid_rst_err", bus.err, 1'b0);
        chk("mid_rst_rdata", bus.rdata, 0);
        chk("mid_rst_sel", bus.sel, 2'd0);
        chk("mid_rst_mem_req", bus.mem_req, 1'b0);
        chk("mid_rst_mem_we", bus.mem_we, 1'b0);
        model_reset();
        drive();
        @(negedge clk);
        reset = 1'b0;
        mr = 1'b1;
        md = 16'hBEEF;
        drive();
        @(negedge clk);
        mr = 1'b0;
        drive();
        repeat (2) begin
            @(negedge clk);
            chk("late_rdy_done", bus.done, 3'b000);
            chk("late_rdy_gnt", bus.gnt, 3'b000);
            chk("late_rdy_rdata", bus.rdata, 0);
            chk("late_rdy_mem_req", bus.mem_req, 1'b0);
        end

        repeat (500) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
